// File: rtl/async_fifo_wr_arb.sv
// async_fifo_wr_arb: round-robin burst arbiter sharing one async FIFO write port (wr_clk domain); optional stall counter via WR_ARB_STALL_CNT_EN
module async_fifo_wr_arb #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 4,
  parameter int MAX_BURST  = 4
) (
  input  logic                          wr_clk,
  input  logic                          wr_rst_n,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            ack,
  output logic [NUM_REQ-1:0]            gnt,
  output logic                          busy,
  input  logic                          fifo_full,
  output logic                          fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         fifo_wr_data
`ifdef WR_ARB_STALL_CNT_EN
  ,
  output logic [15:0]                   stall_cnt
`endif
);
  localparam int BCNT_W = $clog2(MAX_BURST) + 1;
  localparam int IDX_W  = $clog2(NUM_REQ);
  typedef enum logic {IDLE, BURST} state_t;
  state_t                  state, state_n;
  logic [NUM_REQ-1:0]      gnt_n;
  logic [IDX_W-1:0]        rr_ptr, rr_ptr_n, g, pick, cand;
  logic [BCNT_W-1:0]       beat_cnt, beat_cnt_n;
  logic [DATA_WIDTH-1:0]   slices [NUM_REQ];
  logic                    last_beat;
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_slice
    assign slices[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
  end
  assign busy      = (state == BURST);
  assign last_beat = (beat_cnt == BCNT_W'(MAX_BURST - 1));
  // decode the one-hot grant into an index and pick the next requester in rotation order from rr_ptr
  always_comb begin
    g    = '0;
    pick = '0;
    cand = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (gnt[i]) g = IDX_W'(i);
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = IDX_W'((int'(rr_ptr) + k) % NUM_REQ);
      if (req[cand]) pick = cand;
    end
  end
  // write-port datapath: only the granted requester can write, and never while full
  always_comb begin
    fifo_wr_en   = busy && req[g] && !fifo_full;
    ack          = fifo_wr_en ? gnt : '0;
    fifo_wr_data = busy ? slices[g] : '0;
  end
  // next-state: grant in IDLE, count beats in BURST, exit on burst limit or dropped request
  always_comb begin
    state_n    = state;
    gnt_n      = gnt;
    rr_ptr_n   = rr_ptr;
    beat_cnt_n = beat_cnt;
    if (state == IDLE) begin
      if (|req) begin
        state_n     = BURST;
        gnt_n       = '0;
        gnt_n[pick] = 1'b1;
        beat_cnt_n  = '0;
      end
    end else if (!req[g] || (fifo_wr_en && last_beat)) begin
      state_n  = IDLE;
      gnt_n    = '0;
      rr_ptr_n = (g == IDX_W'(NUM_REQ - 1)) ? '0 : g + 1'b1;
    end else if (fifo_wr_en) begin
      beat_cnt_n = beat_cnt + 1'b1;
    end
  end
  // arbiter state registers
  always_ff @(posedge wr_clk or negedge wr_rst_n) begin
    if (!wr_rst_n) begin
      state    <= IDLE;
      gnt      <= '0;
      rr_ptr   <= '0;
      beat_cnt <= '0;
    end else begin
      state    <= state_n;
      gnt      <= gnt_n;
      rr_ptr   <= rr_ptr_n;
      beat_cnt <= beat_cnt_n;
    end
  end
`ifdef WR_ARB_STALL_CNT_EN
  // saturating count of cycles where the granted requester is blocked by full
  always_ff @(posedge wr_clk or negedge wr_rst_n) begin
    if (!wr_rst_n)
      stall_cnt <= '0;
    else if (busy && req[g] && fifo_full && stall_cnt != 16'hFFFF)
      stall_cnt <= stall_cnt + 16'd1;
  end
`endif
endmodule

// File: tb/tb_async_fifo_wr_arb.sv
// tb_async_fifo_wr_arb: directed scenarios plus randomized run against a behavioural arbiter model
module tb_async_fifo_wr_arb;
  localparam int NR = 4;
  localparam int DW = 4;
  localparam int MB = 4;
  logic              wr_clk = 1'b0;
  logic              wr_rst_n = 1'b0;
  logic [NR-1:0]     req = '0;
  logic [NR*DW-1:0]  req_data = '0;
  logic [NR-1:0]     ack, gnt;
  logic              busy, fifo_full = 1'b0, fifo_wr_en;
  logic [DW-1:0]     fifo_wr_data;
`ifdef WR_ARB_STALL_CNT_EN
  logic [15:0]       stall_cnt;
`endif
  int checks = 0;
  int failures = 0;
  int rem [NR];
  logic [DW-1:0] dat [NR];
  bit rnd = 0;
  bit full_cfg = 0;

  async_fifo_wr_arb #(.NUM_REQ(NR), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
    .wr_clk(wr_clk),
    .wr_rst_n(wr_rst_n),
    .req(req),
    .req_data(req_data),
    .ack(ack),
    .gnt(gnt),
    .busy(busy),
    .fifo_full(fifo_full),
    .fifo_wr_en(fifo_wr_en),
    .fifo_wr_data(fifo_wr_data)
`ifdef WR_ARB_STALL_CNT_EN
    ,
    .stall_cnt(stall_cnt)
`endif
  );

  always #5 wr_clk = ~wr_clk;

  initial begin
    #10_000_000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

  task automatic do_reset();
    wr_rst_n = 1'b0;
    rnd = 0;
    full_cfg = 0;
    for (int i = 0; i < NR; i++) begin
      rem[i] = 0;
      dat[i] = '0;
    end
    req = '0;
    req_data = '0;
    fifo_full = 1'b0;
    repeat (2) @(posedge wr_clk);
    #1 wr_rst_n = 1'b1;
    #1;
  endtask

  // one clock of requester behaviour: consume acked beats, then drive req/data/full
  task automatic step();
    logic [NR-1:0] a;
    a = ack;
    @(posedge wr_clk);
    #1;
    for (int i = 0; i < NR; i++) begin
      if (a[i]) begin
        rem[i]--;
        dat[i] = rnd ? DW'($urandom) : dat[i] + 1'b1;
      end
      if (rnd && rem[i] == 0 && $urandom_range(0, 3) == 0) rem[i] = $urandom_range(1, 9);
      req[i] = rem[i] > 0;
      req_data[i*DW +: DW] = dat[i];
    end
    fifo_full = rnd ? ($urandom_range(0, 3) == 0) : full_cfg;
    #1;
  endtask

  task automatic test_reset();
    wr_rst_n = 1'b0;
    req = '1;
    req_data = 16'hA5C3;
    fifo_full = 1'b0;
    #1;
    checks++;
    if (gnt !== 0 || busy !== 0 || ack !== 0 || fifo_wr_en !== 0 || fifo_wr_data !== 0) begin
      failures++;
      $display("FAIL reset_outputs gnt=%b busy=%b ack=%b wr_en=%b data=%h expected all zero", gnt, busy, ack, fifo_wr_en, fifo_wr_data);
    end
    repeat (2) @(posedge wr_clk);
    #1;
    checks++;
    if (gnt !== 0 || busy !== 0 || fifo_wr_en !== 0) begin
      failures++;
      $display("FAIL reset_held gnt=%b busy=%b wr_en=%b expected all zero", gnt, busy, fifo_wr_en);
    end
  endtask

  task automatic test_single();
    int nw = 0;
    int first = -1;
    int offs [6] = '{0, 1, 2, 3, 5, 6};
    do_reset();
    rem[0] = 6;
    dat[0] = 4'd1;
    for (int c = 0; c < 12; c++) begin
      step();
      if (c == 0) begin
        checks++;
        if (busy !== 1'b0 || fifo_wr_en !== 1'b0) begin
          failures++;
          $display("FAIL single_idle busy=%b wr_en=%b expected 0 0", busy, fifo_wr_en);
        end
      end
      if (c == 1) begin
        checks++;
        if (gnt !== 4'b0001) begin
          failures++;
          $display("FAIL single_gnt gnt=%b expected 0001", gnt);
        end
      end
      if (c == 5) begin
        checks++;
        if (busy !== 1'b0 || gnt !== 4'b0000) begin
          failures++;
          $display("FAIL single_gap busy=%b gnt=%b expected 0 0000", busy, gnt);
        end
      end
      if (fifo_wr_en === 1'b1) begin
        if (first < 0) first = c;
        checks++;
        if (nw >= 6) begin
          failures++;
          $display("FAIL single_extra_write data=%h expected no write", fifo_wr_data);
        end else if (fifo_wr_data !== DW'(nw + 1) || c - first != offs[nw]) begin
          failures++;
          $display("FAIL single_write data=%h offset=%0d expected data=%h offset=%0d", fifo_wr_data, c - first, DW'(nw + 1), offs[nw]);
        end
        nw++;
      end
    end
    checks++;
    if (nw != 6 || busy !== 1'b0 || gnt !== 4'b0000) begin
      failures++;
      $display("FAIL single_end writes=%0d busy=%b gnt=%b expected 6 0 0000", nw, busy, gnt);
    end
  endtask

  task automatic test_all_req();
    int nw = 0;
    int own;
    do_reset();
    for (int i = 0; i < NR; i++) begin
      rem[i] = 100;
      dat[i] = DW'(i * 4);
    end
    for (int c = 0; c < 25; c++) begin
      step();
      if (fifo_wr_en === 1'b1) begin
        own = -1;
        for (int i = 0; i < NR; i++) if (ack[i]) own = i;
        checks++;
        if (own != (nw / MB) % NR || !$onehot(ack) || ack !== gnt || fifo_wr_data !== dat[(nw / MB) % NR]) begin
          failures++;
          $display("FAIL all_req_beat%0d ack=%b gnt=%b data=%h expected owner %0d data=%h", nw, ack, gnt, fifo_wr_data, (nw / MB) % NR, dat[(nw / MB) % NR]);
        end
        nw++;
      end
    end
    checks++;
    if (nw != 20) begin
      failures++;
      $display("FAIL all_req_count writes=%0d expected 20", nw);
    end
  endtask

  task automatic test_full_stall();
    int nw = 0;
    bit exp_wr;
    do_reset();
    rem[0] = 4;
    dat[0] = 4'd1;
    for (int c = 0; c < 10; c++) begin
      full_cfg = (c >= 3 && c <= 5);
      step();
      exp_wr = (c == 1 || c == 2 || c == 6 || c == 7);
      checks++;
      if (fifo_wr_en !== exp_wr) begin
        failures++;
        $display("FAIL full_wr_en cycle=%0d wr_en=%b expected %b", c, fifo_wr_en, exp_wr);
      end
      if (fifo_wr_en === 1'b1) begin
        nw++;
        checks++;
        if (fifo_wr_data !== DW'(nw) || fifo_full !== 1'b0) begin
          failures++;
          $display("FAIL full_data cycle=%0d data=%h full=%b expected %h 0", c, fifo_wr_data, fifo_full, DW'(nw));
        end
      end
      if (c >= 3 && c <= 5) begin
        checks++;
        if (ack !== 4'b0000 || gnt !== 4'b0001) begin
          failures++;
          $display("FAIL full_hold cycle=%0d ack=%b gnt=%b expected 0000 0001", c, ack, gnt);
        end
      end
    end
    checks++;
    if (nw != 4) begin
      failures++;
      $display("FAIL full_total writes=%0d expected 4", nw);
    end
  endtask

  task automatic test_drop();
    do_reset();
    rem[2] = 1;
    rem[3] = 2;
    dat[2] = 4'd5;
    dat[3] = 4'd9;
    step();
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL drop_idle busy=%b expected 0", busy);
    end
    step();
    checks++;
    if (gnt !== 4'b0100 || fifo_wr_en !== 1'b1 || fifo_wr_data !== 4'd5) begin
      failures++;
      $display("FAIL drop_beat gnt=%b wr_en=%b data=%h expected 0100 1 5", gnt, fifo_wr_en, fifo_wr_data);
    end
    rem[0] = 1;
    step();
    checks++;
    if (gnt !== 4'b0100 || fifo_wr_en !== 1'b0 || ack !== 4'b0000) begin
      failures++;
      $display("FAIL drop_cycle gnt=%b wr_en=%b ack=%b expected 0100 0 0000", gnt, fifo_wr_en, ack);
    end
    step();
    checks++;
    if (gnt !== 4'b0000 || busy !== 1'b0) begin
      failures++;
      $display("FAIL drop_exit gnt=%b busy=%b expected 0000 0", gnt, busy);
    end
    step();
    checks++;
    if (gnt !== 4'b1000) begin
      failures++;
      $display("FAIL drop_rotate gnt=%b expected 1000", gnt);
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    rem[1] = 10;
    dat[1] = 4'd3;
    repeat (3) step();
    checks++;
    if (gnt !== 4'b0010 || fifo_wr_en !== 1'b1) begin
      failures++;
      $display("FAIL midrst_pre gnt=%b wr_en=%b expected 0010 1", gnt, fifo_wr_en);
    end
    wr_rst_n = 1'b0;
    #1;
    checks++;
    if (gnt !== 0 || busy !== 0 || fifo_wr_en !== 0 || ack !== 0) begin
      failures++;
      $display("FAIL midrst_now gnt=%b busy=%b wr_en=%b ack=%b expected all zero", gnt, busy, fifo_wr_en, ack);
    end
    rem[0] = 5;
    repeat (2) step();
    wr_rst_n = 1'b1;
    step();
    checks++;
    if (gnt !== 4'b0001) begin
      failures++;
      $display("FAIL midrst_regrant gnt=%b expected 0001", gnt);
    end
  endtask

  // model: one owner at a time, bursts of at most MB writes, next owner = first pending after the last owner
  task automatic test_random();
    int mg = -1;
    int mptr = 0;
    int mb = 0;
    logic [NR-1:0] eg, ea;
    logic [DW-1:0] ed;
    bit ew;
    do_reset();
    rnd = 1;
    for (int c = 0; c < 3000; c++) begin
      step();
      eg = '0;
      if (mg >= 0) eg[mg] = 1'b1;
      ew = (mg >= 0) && req[mg] && !fifo_full;
      ea = ew ? eg : '0;
      ed = (mg >= 0) ? req_data[mg*DW +: DW] : '0;
      checks++;
      if (gnt !== eg || busy !== (mg >= 0) || fifo_wr_en !== ew || ack !== ea || fifo_wr_data !== ed) begin
        failures++;
        if (failures < 20)
          $display("FAIL random cycle=%0d gnt=%b busy=%b wr_en=%b ack=%b data=%h expected %b %b %b %b %h", c, gnt, busy, fifo_wr_en, ack, fifo_wr_data, eg, mg >= 0, ew, ea, ed);
      end
      if (mg < 0) begin
        for (int k = NR - 1; k >= 0; k--) if (req[(mptr + k) % NR]) mg = (mptr + k) % NR;
        mb = 0;
      end else if (!req[mg] || (ew && mb == MB - 1)) begin
        mptr = (mg + 1) % NR;
        mg = -1;
      end else if (ew) begin
        mb++;
      end
    end
    rnd = 0;
  endtask

`ifdef WR_ARB_STALL_CNT_EN
  task automatic test_stall_cnt();
    do_reset();
    rem[0] = 3;
    step();
    step();
    checks++;
    if (stall_cnt !== 16'd0) begin
      failures++;
      $display("FAIL stall_start stall_cnt=%0d expected 0", stall_cnt);
    end
    full_cfg = 1;
    repeat (5) step();
    full_cfg = 0;
    step();
    checks++;
    if (stall_cnt !== 16'd5) begin
      failures++;
      $display("FAIL stall_five stall_cnt=%0d expected 5", stall_cnt);
    end
    full_cfg = 1;
    step();
    repeat (70000) @(posedge wr_clk);
    #1;
    checks++;
    if (stall_cnt !== 16'hFFFF || gnt !== 4'b0001) begin
      failures++;
      $display("FAIL stall_saturate stall_cnt=%h gnt=%b expected ffff 0001", stall_cnt, gnt);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_all_req();
    test_full_stall();
    test_drop();
    test_mid_reset();
    test_random();
`ifdef WR_ARB_STALL_CNT_EN
    test_stall_cnt();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
